// File: rtl/soric_xbar.sv
// soric_xbar: read/write crossbar between MASTERS data masters and SLAVES
// slave ports on the req/gnt/rvalid bus.
//   master_*_i / master_*_o : per-master request, address, write, byte enable,
//                             write data in; grant, response strobe, read data,
//                             decode error out (all packed, master m at slice m)
//   slave_*_o / slave_*_i   : per-slave request, address (low address bits),
//                             write, byte enable, write data out; grant,
//                             response strobe, read data in
// Each master and each slave may hold one outstanding transaction. Every slave
// has its own round-robin arbiter. Addresses that decode to no slave are
// answered locally with an error response one cycle after the grant.
module soric_xbar #(
  parameter int MASTERS       = 4,
  parameter int SLAVES        = 5,
  parameter int MASTER_ADDR_W = 14,
  parameter int SLAVE_ADDR_W  = 11,
  parameter int DATA_W        = 32,
  parameter logic [SLAVES*MASTER_ADDR_W-1:0] ADDR_MATCH =
    {14'h2000, 14'h1800, 14'h1000, 14'h0800, 14'h0000},
  parameter logic [SLAVES*MASTER_ADDR_W-1:0] ADDR_MASK = {SLAVES{14'h3800}},
  parameter logic [DATA_W-1:0] ERR_RDATA = 32'h0000_0000
) (
  input  logic                              clk_i,
  input  logic                              reset_ni,
  input  logic [MASTERS-1:0]                master_req_i,
  input  logic [MASTERS*MASTER_ADDR_W-1:0]  master_addr_i,
  input  logic [MASTERS-1:0]                master_we_i,
  input  logic [MASTERS*(DATA_W/8)-1:0]     master_be_i,
  input  logic [MASTERS*DATA_W-1:0]         master_wdata_i,
  output logic [MASTERS-1:0]                master_gnt_o,
  output logic [MASTERS-1:0]                master_rvalid_o,
  output logic [MASTERS*DATA_W-1:0]         master_rdata_o,
  output logic [MASTERS-1:0]                master_err_o,
  output logic [SLAVES-1:0]                 slave_req_o,
  output logic [SLAVES*SLAVE_ADDR_W-1:0]    slave_addr_o,
  output logic [SLAVES-1:0]                 slave_we_o,
  output logic [SLAVES*(DATA_W/8)-1:0]      slave_be_o,
  output logic [SLAVES*DATA_W-1:0]          slave_wdata_o,
  input  logic [SLAVES-1:0]                 slave_gnt_i,
  input  logic [SLAVES-1:0]                 slave_rvalid_i,
  input  logic [SLAVES*DATA_W-1:0]          slave_rdata_i
);

  localparam int AW   = MASTER_ADDR_W;
  localparam int SAW  = SLAVE_ADDR_W;
  localparam int DW   = DATA_W;
  localparam int BEW  = DATA_W / 8;
  localparam int MIW  = (MASTERS > 1) ? $clog2(MASTERS) : 1;
  localparam int SIW  = (SLAVES > 1) ? $clog2(SLAVES) : 1;

  // Per-master state
  logic [MASTERS-1:0] r_m_pend;
  logic [MASTERS-1:0] r_m_err;
  logic [SIW-1:0]     r_m_tgt [MASTERS];
  // Per-slave state
  logic [SLAVES-1:0]  r_s_busy;
  logic [MIW-1:0]     r_s_own [SLAVES];
  logic [MIW-1:0]     r_s_ptr [SLAVES];

  logic [MASTERS-1:0] w_hit;
  logic [SIW-1:0]     w_tgt [MASTERS];
  logic [MASTERS-1:0] w_elig;
  logic [MASTERS-1:0] w_derr;
  logic [MASTERS-1:0] w_m_rsp;
  logic [SLAVES-1:0]  w_win_vld;
  logic [MIW-1:0]     w_win [SLAVES];
  logic [SLAVES-1:0]  w_hs;
  logic [SLAVES-1:0]  w_resp;

  // Address decode: scanning from the top slice down lets the lowest
  // matching slave index overwrite any higher one.
  always_comb begin
    for (int m = 0; m < MASTERS; m++) begin
      w_hit[m] = 1'b0;
      w_tgt[m] = '0;
      for (int s = SLAVES - 1; s >= 0; s--) begin
        if ((master_addr_i[m*AW +: AW] & ADDR_MASK[s*AW +: AW]) == ADDR_MATCH[s*AW +: AW]) begin
          w_hit[m] = 1'b1;
          w_tgt[m] = SIW'(s);
        end
      end
    end
  end

  assign w_elig = master_req_i & ~r_m_pend;
  // Unmapped accesses are granted immediately, without arbitration.
  assign w_derr = w_elig & ~w_hit & {MASTERS{reset_ni}};

  // Round-robin arbitration: search starts one past the last winner.
  always_comb begin
    int idx;
    idx = 0;
    for (int s = 0; s < SLAVES; s++) begin
      w_win_vld[s] = 1'b0;
      w_win[s]     = '0;
      for (int k = 1; k <= MASTERS; k++) begin
        idx = (int'(r_s_ptr[s]) + k) % MASTERS;
        if (!w_win_vld[s] && reset_ni && !r_s_busy[s] && w_elig[idx] &&
            w_hit[idx] && (w_tgt[idx] == SIW'(s))) begin
          w_win_vld[s] = 1'b1;
          w_win[s]     = MIW'(idx);
        end
      end
      w_hs[s]   = w_win_vld[s] & slave_gnt_i[s];
      w_resp[s] = slave_rvalid_i[s] & r_s_busy[s];
    end
  end

  // Slave-side request mux; unselected slaves see all zeros.
  always_comb begin
    slave_req_o   = '0;
    slave_addr_o  = '0;
    slave_we_o    = '0;
    slave_be_o    = '0;
    slave_wdata_o = '0;
    for (int s = 0; s < SLAVES; s++) begin
      if (w_win_vld[s]) begin
        slave_req_o[s]                = 1'b1;
        slave_addr_o[s*SAW +: SAW]    = master_addr_i[int'(w_win[s])*AW +: SAW];
        slave_we_o[s]                 = master_we_i[w_win[s]];
        slave_be_o[s*BEW +: BEW]      = master_be_i[int'(w_win[s])*BEW +: BEW];
        slave_wdata_o[s*DW +: DW]     = master_wdata_i[int'(w_win[s])*DW +: DW];
      end
    end
  end

  // Master-side grant and response routing. A slave response is only
  // forwarded when that slave is busy on behalf of this very master.
  always_comb begin
    master_gnt_o    = w_derr;
    master_rvalid_o = '0;
    master_rdata_o  = '0;
    master_err_o    = '0;
    w_m_rsp         = '0;
    for (int s = 0; s < SLAVES; s++) begin
      if (w_hs[s]) master_gnt_o[w_win[s]] = 1'b1;
    end
    for (int m = 0; m < MASTERS; m++) begin
      if (r_m_pend[m] && r_m_err[m]) begin
        master_rvalid_o[m]         = 1'b1;
        master_err_o[m]            = 1'b1;
        master_rdata_o[m*DW +: DW] = ERR_RDATA;
      end else if (r_m_pend[m] && slave_rvalid_i[int'(r_m_tgt[m])] &&
                   r_s_busy[int'(r_m_tgt[m])] &&
                   (r_s_own[int'(r_m_tgt[m])] == MIW'(m))) begin
        master_rvalid_o[m]         = 1'b1;
        w_m_rsp[m]                 = 1'b1;
        master_rdata_o[m*DW +: DW] = slave_rdata_i[int'(r_m_tgt[m])*DW +: DW];
      end
    end
  end

  // State update: handshake sets ownership, response releases it.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      r_m_pend <= '0;
      r_m_err  <= '0;
      r_s_busy <= '0;
      for (int m = 0; m < MASTERS; m++) r_m_tgt[m] <= '0;
      for (int s = 0; s < SLAVES; s++) begin
        r_s_own[s] <= '0;
        r_s_ptr[s] <= MIW'(MASTERS - 1);
      end
    end else begin
      for (int m = 0; m < MASTERS; m++) begin
        if (w_derr[m]) begin
          r_m_pend[m] <= 1'b1;
          r_m_err[m]  <= 1'b1;
        end else if (r_m_err[m] || w_m_rsp[m]) begin
          r_m_pend[m] <= 1'b0;
          r_m_err[m]  <= 1'b0;
        end
      end
      for (int s = 0; s < SLAVES; s++) begin
        if (w_hs[s]) begin
          r_s_busy[s]          <= 1'b1;
          r_s_own[s]           <= w_win[s];
          r_s_ptr[s]           <= w_win[s];
          r_m_pend[w_win[s]]   <= 1'b1;
          r_m_tgt[w_win[s]]    <= SIW'(s);
        end else if (w_resp[s]) begin
          r_s_busy[s] <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_soric_xbar.sv
// Scripted bench for soric_xbar with its default parameters. Expected
// responses are queued when the bench drives the stimulus that causes them
// and are checked by a monitor whenever a master rvalid appears.
module tb_soric_xbar;

  localparam int M  = 4;
  localparam int S  = 5;
  localparam int AW = 14;
  localparam int SAW = 11;
  localparam int DW = 32;

  logic              clk_i = 1'b0;
  logic              reset_ni;
  logic [M-1:0]      m_req;
  logic [M*AW-1:0]   m_addr;
  logic [M-1:0]      m_we;
  logic [M*4-1:0]    m_be;
  logic [M*DW-1:0]   m_wdata;
  logic [M-1:0]      m_gnt;
  logic [M-1:0]      m_rvalid;
  logic [M*DW-1:0]   m_rdata;
  logic [M-1:0]      m_err;
  logic [S-1:0]      s_req;
  logic [S*SAW-1:0]  s_addr;
  logic [S-1:0]      s_we;
  logic [S*4-1:0]    s_be;
  logic [S*DW-1:0]   s_wdata;
  logic [S-1:0]      s_gnt;
  logic [S-1:0]      s_rvalid;
  logic [S*DW-1:0]   s_rdata;

  soric_xbar dut (
    .clk_i(clk_i), .reset_ni(reset_ni),
    .master_req_i(m_req), .master_addr_i(m_addr), .master_we_i(m_we),
    .master_be_i(m_be), .master_wdata_i(m_wdata),
    .master_gnt_o(m_gnt), .master_rvalid_o(m_rvalid),
    .master_rdata_o(m_rdata), .master_err_o(m_err),
    .slave_req_o(s_req), .slave_addr_o(s_addr), .slave_we_o(s_we),
    .slave_be_o(s_be), .slave_wdata_o(s_wdata),
    .slave_gnt_i(s_gnt), .slave_rvalid_i(s_rvalid), .slave_rdata_i(s_rdata)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    int          m;
    logic [31:0] d;
    logic        e;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic push(input int m, input logic [31:0] d, input logic e);
    exp_t x;
    x.m = m; x.d = d; x.e = e;
    q.push_back(x);
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic clear_in();
    m_req = '0; m_addr = '0; m_we = '0; m_be = '0; m_wdata = '0;
    s_gnt = '0; s_rvalid = '0; s_rdata = '0;
  endtask

  task automatic set_m(input int m, input logic [13:0] a, input logic we, input logic [31:0] wd);
    m_req[m]           = 1'b1;
    m_addr[m*AW +: AW] = a;
    m_we[m]            = we;
    m_be[m*4 +: 4]     = 4'hF;
    m_wdata[m*DW +: DW] = wd;
  endtask

  // Response monitor: every rvalid consumes one queued expectation; idle
  // masters must present zero data and no error.
  always @(negedge clk_i) begin
    for (int m = 0; m < M; m++) begin
      if (m_rvalid[m] === 1'b1) begin
        if (q.size() == 0) begin
          chk("sb_unexpected_rvalid", 64'(m), 64'hFFFF);
        end else begin
          mon_e = q.pop_front();
          chk("sb_master", 64'(m), 64'(mon_e.m));
          chk("sb_rdata", 64'(m_rdata[m*DW +: DW]), 64'(mon_e.d));
          chk("sb_err", 64'(m_err[m]), 64'(mon_e.e));
        end
      end else begin
        chk("idle_rdata", 64'(m_rdata[m*DW +: DW]), 64'h0);
        chk("idle_err", 64'(m_err[m]), 64'h0);
      end
    end
  end

  int rr_order [6] = '{0, 1, 3, 0, 1, 3};

  initial begin
    clear_in();
    reset_ni = 1'b0;
    // Reset: a live request must not leak through
    set_m(0, 14'h0804, 1'b0, 32'h0);
    s_gnt = '1;
    @(negedge clk_i);
    chk("rst_slave_req", 64'(s_req), 64'h0);
    chk("rst_gnt", 64'(m_gnt), 64'h0);
    chk("rst_rvalid", 64'(m_rvalid), 64'h0);
    chk("rst_err", 64'(m_err), 64'h0);
    step();
    clear_in();
    reset_ni = 1'b1;
    step();

    // Single read
    set_m(0, 14'h0804, 1'b0, 32'h0);
    s_gnt[1] = 1'b1;
    @(negedge clk_i);
    chk("rd_slave_req", 64'(s_req), 64'h02);
    chk("rd_slave_addr", 64'(s_addr[1*SAW +: SAW]), 64'h004);
    chk("rd_gnt", 64'(m_gnt), 64'h1);
    step();
    clear_in();
    s_rvalid[1] = 1'b1;
    s_rdata[1*DW +: DW] = 32'hCAFE_0001;
    push(0, 32'hCAFE_0001, 1'b0);
    @(negedge clk_i);
    chk("rd_rvalid", 64'(m_rvalid), 64'h1);
    step();
    clear_in();

    // Round-robin on slave 0
    for (int i = 0; i < 6; i++) begin
      set_m(0, 14'h0010, 1'b0, 32'h0);
      set_m(1, 14'h0020, 1'b0, 32'h0);
      set_m(3, 14'h0030, 1'b0, 32'h0);
      s_gnt[0] = 1'b1;
      s_rvalid = '0;
      @(negedge clk_i);
      chk($sformatf("rr_gnt%0d", i), 64'(m_gnt), 64'(1 << rr_order[i]));
      step();
      s_rvalid[0] = 1'b1;
      s_rdata[0 +: DW] = 32'h1000 + i;
      push(rr_order[i], 32'h1000 + i, 1'b0);
      @(negedge clk_i);
      chk($sformatf("rr_gap%0d", i), 64'(m_gnt), 64'h0);
      step();
    end
    clear_in();
    step();

    // Back-pressure on slave 2
    set_m(1, 14'h1004, 1'b0, 32'h0);
    set_m(2, 14'h1008, 1'b0, 32'h0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_i);
      chk($sformatf("bp_stall_gnt%0d", i), 64'(m_gnt), 64'h0);
      chk($sformatf("bp_stall_req%0d", i), 64'(s_req), 64'h04);
      chk($sformatf("bp_stall_addr%0d", i), 64'(s_addr[2*SAW +: SAW]), 64'h004);
      step();
    end
    s_gnt[2] = 1'b1;
    @(negedge clk_i);
    chk("bp_first_gnt", 64'(m_gnt), 64'h2);
    step();
    m_req[1] = 1'b0;
    s_rvalid[2] = 1'b1;
    s_rdata[2*DW +: DW] = 32'h0000_00B1;
    push(1, 32'h0000_00B1, 1'b0);
    @(negedge clk_i);
    chk("bp_busy_gnt", 64'(m_gnt), 64'h0);
    step();
    s_rvalid[2] = 1'b0;
    @(negedge clk_i);
    chk("bp_second_gnt", 64'(m_gnt), 64'h4);
    chk("bp_second_addr", 64'(s_addr[2*SAW +: SAW]), 64'h008);
    step();
    m_req[2] = 1'b0;
    s_rvalid[2] = 1'b1;
    s_rdata[2*DW +: DW] = 32'h0000_00B2;
    push(2, 32'h0000_00B2, 1'b0);
    step();
    clear_in();

    // Decode error
    set_m(2, 14'h3000, 1'b0, 32'h0);
    s_gnt = '1;
    @(negedge clk_i);
    chk("de_gnt", 64'(m_gnt), 64'h4);
    chk("de_slave_req", 64'(s_req), 64'h0);
    chk("de_no_early_rvalid", 64'(m_rvalid), 64'h0);
    push(2, 32'h0000_0000, 1'b1);
    step();
    m_req[2] = 1'b0;
    @(negedge clk_i);
    chk("de_rvalid", 64'(m_rvalid), 64'h4);
    chk("de_err", 64'(m_err), 64'h4);
    chk("de_slave_req2", 64'(s_req), 64'h0);
    step();
    @(negedge clk_i);
    chk("de_done", 64'(m_rvalid), 64'h0);
    clear_in();
    step();

    // Parallel: master 0 reads slave 3, master 1 writes slave 4
    set_m(0, 14'h1808, 1'b0, 32'h0);
    set_m(1, 14'h200C, 1'b1, 32'hDEAD_BEEF);
    s_gnt[3] = 1'b1;
    s_gnt[4] = 1'b1;
    @(negedge clk_i);
    chk("par_gnt", 64'(m_gnt), 64'h3);
    chk("par_slave_req", 64'(s_req), 64'h18);
    chk("par_addr3", 64'(s_addr[3*SAW +: SAW]), 64'h008);
    chk("par_addr4", 64'(s_addr[4*SAW +: SAW]), 64'h00C);
    chk("par_we4", 64'(s_we), 64'h10);
    chk("par_wdata4", 64'(s_wdata[4*DW +: DW]), 64'hDEAD_BEEF);
    step();
    m_req = '0;
    s_rvalid[3] = 1'b1;
    s_rdata[3*DW +: DW] = 32'h0000_0033;
    push(0, 32'h0000_0033, 1'b0);
    @(negedge clk_i);
    chk("par_rv0", 64'(m_rvalid), 64'h1);
    step();
    s_rvalid = '0;
    s_rvalid[4] = 1'b1;
    s_rdata[4*DW +: DW] = 32'h0000_0044;
    push(1, 32'h0000_0044, 1'b0);
    @(negedge clk_i);
    chk("par_rv1", 64'(m_rvalid), 64'h2);
    step();
    s_rvalid = '0;
    s_rvalid[0] = 1'b1;
    @(negedge clk_i);
    chk("stray_rvalid", 64'(m_rvalid), 64'h0);
    step();
    clear_in();

    // Reset while slave 4 still owes a response
    set_m(0, 14'h2000, 1'b0, 32'h0);
    s_gnt[4] = 1'b1;
    @(negedge clk_i);
    chk("mr_gnt", 64'(m_gnt), 64'h1);
    step();
    reset_ni = 1'b0;
    set_m(1, 14'h2010, 1'b0, 32'h0);
    s_rvalid[4] = 1'b1;
    @(negedge clk_i);
    chk("mr_slave_req", 64'(s_req), 64'h0);
    chk("mr_gnt_rst", 64'(m_gnt), 64'h0);
    chk("mr_rvalid_rst", 64'(m_rvalid), 64'h0);
    chk("mr_err_rst", 64'(m_err), 64'h0);
    step();
    m_req = '0;
    reset_ni = 1'b1;
    @(negedge clk_i);
    chk("mr_no_late_rvalid", 64'(m_rvalid), 64'h0);
    step();
    s_rvalid = '0;
    set_m(0, 14'h2000, 1'b0, 32'h0);
    set_m(1, 14'h2010, 1'b0, 32'h0);
    @(negedge clk_i);
    chk("mr_post_gnt", 64'(m_gnt), 64'h1);
    step();
    m_req[0] = 1'b0;
    m_req[1] = 1'b0;
    s_rvalid[4] = 1'b1;
    s_rdata[4*DW +: DW] = 32'h0000_0055;
    push(0, 32'h0000_0055, 1'b0);
    step();
    clear_in();
    step();

    chk("sb_empty", 64'(q.size()), 64'h0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/soric_xbar.md
# soric_xbar

Parametrised read/write crossbar joining SoRIC data masters (cores, Wishbone host bridge, UART loader) to SRAM banks and peripherals over the req/gnt/rvalid bus. It generalises the fixed data interconnect to any master and slave count. It adds per-slave round-robin arbitration and honours real slave `rvalid` and `gnt` back-pressure. Unmapped addresses receive a decode-error response instead of being dropped.

## Interface
- `MASTERS`, 4, number of master ports
- `SLAVES`, 5, number of slave ports
- `MASTER_ADDR_W`, 14, master address width
- `SLAVE_ADDR_W`, 11, slave address width; low bits of the master address
- `DATA_W`, 32, data width; byte enables are `DATA_W/8` wide
- `ADDR_MATCH`, {14'h2000,14'h1800,14'h1000,14'h0800,14'h0000}, `SLAVES*MASTER_ADDR_W` packed; slave s at slice s
- `ADDR_MASK`, {SLAVES{14'h3800}}, same packing as `ADDR_MATCH`
- `ERR_RDATA`, 32'h0000_0000, read data returned with a decode error

Ports:
- `clk_i` in 1: the only clock
- `reset_ni` in 1: asynchronous active-low reset
- `master_req_i` in MASTERS: request; held until granted
- `master_addr_i` in MASTERS*MASTER_ADDR_W: address
- `master_we_i` in MASTERS: 1 = write
- `master_be_i` in MASTERS*DATA_W/8: byte enables
- `master_wdata_i` in MASTERS*DATA_W: write data
- `master_gnt_o` out MASTERS: request accepted this cycle
- `master_rvalid_o` out MASTERS: one-cycle response strobe, asserted for both reads and writes
- `master_rdata_o` out MASTERS*DATA_W: read data, valid with `rvalid`
- `master_err_o` out MASTERS: decode error, valid with `rvalid`
- `slave_req_o` out SLAVES: request
- `slave_addr_o` out SLAVES*SLAVE_ADDR_W: address
- `slave_we_o` out SLAVES: write enable
- `slave_be_o` out SLAVES*DATA_W/8: byte enables
- `slave_wdata_o` out SLAVES*DATA_W: write data
- `slave_gnt_i` in SLAVES: slave accepts request
- `slave_rvalid_i` in SLAVES: response strobe; at least one cycle after the slave's handshake
- `slave_rdata_i` in SLAVES*DATA_W: read data

## Operation
- **Address decode:** master m targets slave s when `(addr & MASK[s]) == MATCH[s]`. If several slaves match, the lowest s wins. If none match, the access is a decode error.
- **Master state registers:**
  - `m_pend`: one outstanding transaction allowed per master.
  - `m_tgt`: slave index of the outstanding transaction.
  - `m_err`: set when the outstanding transaction is a decode error.
- **Slave state registers:**
  - `s_busy`: one outstanding transaction allowed per slave.
  - `s_own`: index of the master that owns the outstanding transaction.
  - `s_ptr`: round-robin pointer.
- **Eligibility:**
  - A master is eligible when `master_req_i[m]` is high and `m_pend` is 0.
  - A slave can be requested only when `s_busy` is 0.
- **Arbitration:**
  - Per slave, among eligible masters decoding to it, priority starts at `s_ptr+1` and wraps modulo MASTERS.
  - The winner's addr/we/be/wdata drive the slave outputs and `slave_req_o[s]` = 1.
  - `master_gnt_o[winner] = slave_gnt_i[s]`.
- **Handshake (req & gnt):**
  - Sets `m_pend`, `m_tgt=s`, `s_busy`, `s_own=m`.
  - Sets `s_ptr=m`. The pointer moves only on a completed handshake; a waiting master keeps its priority.
- **Decode error:**
  - An eligible master with an unmapped address gets `master_gnt_o=1` in the same cycle, with no arbitration.
  - It sets `m_pend` and `m_err`.
  - Next cycle: `rvalid=1`, `err=1`, `rdata=ERR_RDATA`, and `m_pend` and `m_err` clear.
  - No slave sees the access.
- **Response:**
  - `slave_rvalid_i[s]` with `s_busy` set drives `master_rvalid_o[s_own]`, passes `rdata` through and sets `err=0`. It clears `s_busy` and the owner's `m_pend`.
  - `rvalid` on a non-busy slave is ignored.
- **Idle outputs:** when `rvalid` is low, `master_rdata_o` = 0 and `master_err_o` = 0. Unselected slave outputs = 0.
- **Different slaves in the same cycle:** handshakes to different slaves proceed in parallel.
- **Reset (asynchronous, or mid-operation):**
  - All `m_pend`, `m_err` and `s_busy` clear.
  - `s_ptr` = MASTERS-1, so master 0 has first priority.
  - Outstanding transactions are discarded and no `rvalid` is generated for them.
  - While `reset_ni` = 0, all `req`, `gnt`, `rvalid` and `err` outputs are 0.

## Timing
- Request to slave and `gnt` to master are combinational in the same cycle, with zero added latency.
- `slave_rvalid_i` to `master_rvalid_o` is combinational in the same cycle.
- Decode-error response comes exactly 1 cycle after the grant.
- A master may be granted again no earlier than the cycle after its `rvalid`. A slave may be requested again no earlier than the cycle after its `rvalid`.
- With a 1-cycle SRAM, throughput is one access per 2 cycles per slave. A hold-off slave (`gnt`=0) stalls only its requesters.

## Test plan
- **Single read:** master 0 reads 14'h0804, slave 1 `gnt`=1, `rvalid` next cycle with rdata 32'hCAFE_0001. Required: `slave_addr_o[1]`=11'h004, `gnt0` in the same cycle, `rvalid0` +1 with 32'hCAFE_0001, `err0`=0.
- **Round-robin:** masters 0, 1 and 3 all request slave 0 continuously, with `gnt`=1 and 1-cycle `rvalid`. Required grant order 0, 1, 3, 0, 1, 3, one grant every 2 cycles.
- **Back-pressure:** slave 2 `gnt`=0 for 3 cycles while masters 1 and 2 request it. Required: master 1 is held with no grant, then granted first on the cycle `gnt` rises, and `s_ptr` is unchanged during the stall.
- **Decode error:** master 2 accesses 14'h3000. Required: `gnt2` in the same cycle, `rvalid2`=1, `err2`=1, rdata=ERR_RDATA +1 cycle, and all `slave_req_o`=0.
- **Parallel and stray:** masters 0 and 1 access slaves 3 and 4 in the same cycle, and both complete independently. A stray `slave_rvalid_i[0]` while idle produces no master `rvalid`.
- **Reset mid-transaction:** assert `reset_ni`=0 after a slave-4 grant, before its `rvalid`. Required: all outputs 0 during reset, no `rvalid` after release, and master 0 wins the first post-reset contention.
